bp_fe_mem_sched: RTL

Front-end memory-command scheduler that sits between the PC generator / FE command path and the FE memory block (I-TLB + I-cache). It arbitrates fence, fill and fetch requests onto the single memory-command channel and tracks the two in-flight fetch stages. It poisons younger fetches when a miss or redirect occurs, and replays a missed fetch once the I-cache refill or I-TLB fill completes.

---
 rtl/bp_fe_mem_sched_if.sv | 69 ++++++
 rtl/bp_fe_mem_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_sched_if.sv
// Signal bundle between the FE memory-command scheduler and its environment
// (PC generator, FE command path, I-TLB/I-cache memory block).
interface bp_fe_mem_sched_if #(
  parameter int vaddr_width_p = 39,
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 40,
  parameter int instr_width_p = 32
);
  logic                     fetch_v_i;
  logic [vaddr_width_p-1:0] fetch_vaddr_i;
  logic                     fetch_yumi_o;

  logic                     fill_v_i;
  logic [vtag_width_p-1:0]  fill_vtag_i;
  logic [entry_width_p-1:0] fill_entry_i;
  logic                     fill_yumi_o;

  logic                     fence_v_i;
  logic                     fence_yumi_o;
  logic                     redirect_v_i;

  logic                     mem_cmd_v_o;
  logic [1:0]               mem_cmd_op_o;
  logic                     mem_cmd_yumi_i;
  logic [vaddr_width_p-1:0] mem_cmd_vaddr_o;
  logic [vtag_width_p-1:0]  mem_cmd_vtag_o;
  logic [entry_width_p-1:0] mem_cmd_entry_o;
  logic                     mem_poison_o;

  logic                     mem_resp_v_i;
  logic                     mem_resp_icache_miss_i;
  logic                     mem_resp_itlb_miss_i;
  logic                     mem_resp_fault_i;
  logic [instr_width_p-1:0] mem_resp_data_i;
  logic                     cache_req_complete_i;

  logic                     resp_v_o;
  logic [vaddr_width_p-1:0] resp_vaddr_o;
  logic [instr_width_p-1:0] resp_data_o;
  logic                     resp_fault_o;

  logic                     itlb_miss_v_o;
  logic [vtag_width_p-1:0]  itlb_miss_vtag_o;

  // The scheduler serves requests, so it takes the slave side.
  modport slave (
    input  fetch_v_i, fetch_vaddr_i, fill_v_i, fill_vtag_i, fill_entry_i,
           fence_v_i, redirect_v_i, mem_cmd_yumi_i,
           mem_resp_v_i, mem_resp_icache_miss_i, mem_resp_itlb_miss_i,
           mem_resp_fault_i, mem_resp_data_i, cache_req_complete_i,
    output fetch_yumi_o, fill_yumi_o, fence_yumi_o,
           mem_cmd_v_o, mem_cmd_op_o, mem_cmd_vaddr_o, mem_cmd_vtag_o,
           mem_cmd_entry_o, mem_poison_o,
           resp_v_o, resp_vaddr_o, resp_data_o, resp_fault_o,
           itlb_miss_v_o, itlb_miss_vtag_o
  );

  modport master (
    output fetch_v_i, fetch_vaddr_i, fill_v_i, fill_vtag_i, fill_entry_i,
           fence_v_i, redirect_v_i, mem_cmd_yumi_i,
           mem_resp_v_i, mem_resp_icache_miss_i, mem_resp_itlb_miss_i,
           mem_resp_fault_i, mem_resp_data_i, cache_req_complete_i,
    input  fetch_yumi_o, fill_yumi_o, fence_yumi_o,
           mem_cmd_v_o, mem_cmd_op_o, mem_cmd_vaddr_o, mem_cmd_vtag_o,
           mem_cmd_entry_o, mem_poison_o,
           resp_v_o, resp_vaddr_o, resp_data_o, resp_fault_o,
           itlb_miss_v_o, itlb_miss_vtag_o
  );
endinterface

// File: rtl/bp_fe_mem_sched.sv
// FE memory-command scheduler: arbitrates fence/fill/fetch onto one command
// channel, tracks two fetch stages, poisons on miss/redirect and replays misses.
module bp_fe_mem_sched #(
  parameter int vaddr_width_p = 39,
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 40,
  parameter int instr_width_p = 32
) (
  input logic              clk_i,
  input logic              reset_n_i,
  bp_fe_mem_sched_if.slave io
);

  typedef enum logic [2:0] {
    S_RUN, S_WAIT_MISS, S_WAIT_FILL, S_REPLAY, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0, OP_FILL = 2'd1, OP_FENCE = 2'd2
  } op_e;

  state_e state_q, state_n;

  logic                     v1_q, v2_q;
  logic [vaddr_width_p-1:0] vaddr1_q, vaddr2_q, replay_vaddr_q;

  logic active, redirect, cmd_yumi;
  logic sel_fence, sel_fill, sel_fetch, sel_replay;
  logic fetch_acc, replay_acc, fill_acc;
  logic rsp_live, rsp_hit, rsp_fault, rsp_imiss, rsp_tmiss, poison;

  // Every output is forced low while reset is held, so the reset gate is
  // folded into the request and response qualifiers below.
  assign active   = reset_n_i;
  assign redirect = active & io.redirect_v_i;
  assign cmd_yumi = active & io.mem_cmd_yumi_i;

  // Fixed priority fence > fill > fetch; external and replay fetch are never
  // eligible in the same state, and neither in a redirect cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    sel_fence  = 1'b0;
    sel_fill   = 1'b0;
    sel_fetch  = 1'b0;
    sel_replay = 1'b0;
    if (active) begin
      sel_fence  = io.fence_v_i;
      sel_fill   = io.fill_v_i & ~sel_fence
                 & ((state_q == S_RUN) | (state_q == S_WAIT_FILL));
      sel_fetch  = io.fetch_v_i & ~sel_fence & ~sel_fill & ~redirect
                 & (state_q == S_RUN);
      sel_replay = ~sel_fence & ~sel_fill & ~redirect & (state_q == S_REPLAY);
    end
  end

  assign fetch_acc  = sel_fetch  & cmd_yumi;
  assign replay_acc = sel_replay & cmd_yumi;
  assign fill_acc   = sel_fill   & cmd_yumi;

  // Response decode for stage 2: fault beats I-cache miss beats I-TLB miss.
  // A redirect flushes the stage-2 fetch, so it retires nothing that cycle.
  assign rsp_live  = active & io.mem_resp_v_i & v2_q;
  assign poison    = redirect
                   | (rsp_live & (io.mem_resp_icache_miss_i
                                | io.mem_resp_itlb_miss_i
                                | io.mem_resp_fault_i));
  assign rsp_fault = rsp_live & ~redirect & io.mem_resp_fault_i;
  assign rsp_imiss = rsp_live & ~redirect & ~io.mem_resp_fault_i
                   & io.mem_resp_icache_miss_i;
  assign rsp_tmiss = rsp_live & ~redirect & ~io.mem_resp_fault_i
                   & ~io.mem_resp_icache_miss_i & io.mem_resp_itlb_miss_i;
  assign rsp_hit   = rsp_live & ~redirect & ~io.mem_resp_fault_i
                   & ~io.mem_resp_icache_miss_i & ~io.mem_resp_itlb_miss_i;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n_i) state_q <= S_RUN;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (redirect)       state_n = S_RUN;
    else if (rsp_fault) state_n = S_HALT;
    else if (rsp_imiss) state_n = S_WAIT_MISS;
    else if (rsp_tmiss) state_n = S_WAIT_FILL;
    else begin
      unique case (state_q)
        S_WAIT_MISS: if (io.cache_req_complete_i) state_n = S_REPLAY;
        S_WAIT_FILL: if (fill_acc)                state_n = S_REPLAY;
        S_REPLAY:    if (replay_acc)              state_n = S_RUN;
        default:     state_n = state_q;
      endcase
    end
  end

  // Two-stage in-flight tracking; the response in a cycle belongs to stage 2.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      vaddr1_q       <= '0;
      vaddr2_q       <= '0;
      replay_vaddr_q <= '0;
    end else begin
      v1_q     <= (fetch_acc | replay_acc) & ~redirect;
      v2_q     <= v1_q & ~poison & ~redirect;
      vaddr2_q <= vaddr1_q;
      if (fetch_acc)       vaddr1_q <= io.fetch_vaddr_i;
      else if (replay_acc) vaddr1_q <= replay_vaddr_q;
      if (redirect)                    replay_vaddr_q <= '0;
      else if (rsp_imiss | rsp_tmiss)  replay_vaddr_q <= vaddr2_q;
    end
  end

  always_comb begin
    io.mem_cmd_v_o     = sel_fence | sel_fill | sel_fetch | sel_replay;
    io.mem_cmd_op_o    = OP_FETCH;
    io.mem_cmd_vaddr_o = '0;
    io.mem_cmd_vtag_o  = '0;
    io.mem_cmd_entry_o = '0;
    if (sel_fence) begin
      io.mem_cmd_op_o = OP_FENCE;
    end else if (sel_fill) begin
      io.mem_cmd_op_o    = OP_FILL;
      io.mem_cmd_vtag_o  = io.fill_vtag_i;
      io.mem_cmd_entry_o = io.fill_entry_i;
    end else if (sel_fetch) begin
      io.mem_cmd_vaddr_o = io.fetch_vaddr_i;
    end else if (sel_replay) begin
      io.mem_cmd_vaddr_o = replay_vaddr_q;
    end

    io.fence_yumi_o = sel_fence & cmd_yumi;
    io.fill_yumi_o  = fill_acc;
    io.fetch_yumi_o = fetch_acc;
    io.mem_poison_o = poison;

    io.resp_v_o     = rsp_hit | rsp_fault;
    io.resp_fault_o = rsp_fault;
    io.resp_vaddr_o = (rsp_hit | rsp_fault) ? vaddr2_q : '0;
    io.resp_data_o  = rsp_hit ? io.mem_resp_data_i : '0;

    io.itlb_miss_v_o    = rsp_tmiss;
    io.itlb_miss_vtag_o = rsp_tmiss ? vaddr2_q[vaddr_width_p-1 -: vtag_width_p] : '0;
  end

endmodule
